// File: rtl/tb_uart_pkg.sv
// +--------------------------------------------------------------------+
// | tb_uart_pkg : shared FSM state type and ASCII constants for tb_uart |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package tb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

`default_nettype wire

// File: rtl/tb_uart_if.sv
// +--------------------------------------------------------------------+
// | tb_uart_if : decoded-byte and line outputs of the UART monitor      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

interface tb_uart_if #(
  parameter int LINE_LEN = 16
);
  localparam int LEN_W = $clog2(LINE_LEN + 1);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;
  logic [8*LINE_LEN-1:0] line_data;
  logic [LEN_W-1:0]      line_len;
  logic                  line_valid;

  modport master (
    output rx_data, rx_valid, frame_err, busy,
    output line_data, line_len, line_valid
  );

  modport slave (
    input rx_data, rx_valid, frame_err, busy,
    input line_data, line_len, line_valid
  );
endinterface

`default_nettype wire

// File: rtl/tb_uart_linebuf.sv
// +--------------------------------------------------------------------+
// | tb_uart_linebuf : assembles received bytes into text lines          |
// | Built only with TB_UART_LINEBUF_EN. Revision 1.0                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_linebuf
  import tb_uart_pkg::*;
#(
  parameter int LINE_LEN = 16,
  parameter int LEN_W    = $clog2(LINE_LEN + 1)
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [8*LINE_LEN-1:0] line_data,
  output logic [LEN_W-1:0]      line_len,
  output logic                  line_valid
);

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(LINE_LEN - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(LINE_LEN);

  logic [LEN_W-1:0] wr_idx;

  // line_data doubles as the storage, so a finished line stays visible
  // until the next line overwrites it byte by byte.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      line_data  <= '0;
      line_len   <= '0;
      line_valid <= 1'b0;
      wr_idx     <= '0;
    end else begin
      line_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_data == ASCII_LF) begin
          line_valid <= 1'b1;
          line_len   <= wr_idx;
          wr_idx     <= '0;
        end else if (rx_data != ASCII_CR) begin
          line_data[{wr_idx, 3'b000} +: 8] <= rx_data;
          if (wr_idx == LAST_IDX) begin
            line_valid <= 1'b1;
            line_len   <= FULL_LEN;
            wr_idx     <= '0;
          end else begin
            wr_idx <= wr_idx + LEN_W'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tb_uart.sv
// +--------------------------------------------------------------------+
// | tb_uart : passive 8N1 receive monitor; optional line assembly under |
// | TB_UART_LINEBUF_EN. Revision 1.0                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 694,
  parameter int LINE_LEN     = 16
) (
  input  logic      clock,
  input  logic      resetb,
  input  logic      ser_rx,
  tb_uart_if.master mon
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1;
  logic             sync2;
  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             busy_r;

  // Synchronizer resets high so a line that is already low after reset
  // still has to be seen as a fresh falling edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sync2) begin
            state  <= ST_START;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (sync2) begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (sync2) begin
              rx_data_r  <= shreg;
              rx_valid_r <= 1'b1;
              state      <= ST_IDLE;
              busy_r     <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it cannot retrigger framing.
          if (sync2) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign mon.rx_data   = rx_data_r;
  assign mon.rx_valid  = rx_valid_r;
  assign mon.frame_err = frame_err_r;
  assign mon.busy      = busy_r;

`ifdef TB_UART_LINEBUF_EN
  tb_uart_linebuf #(
    .LINE_LEN (LINE_LEN)
  ) u_linebuf (
    .clock      (clock),
    .resetb     (resetb),
    .rx_data    (rx_data_r),
    .rx_valid   (rx_valid_r),
    .line_data  (mon.line_data),
    .line_len   (mon.line_len),
    .line_valid (mon.line_valid)
  );
`else
  assign mon.line_data  = '0;
  assign mon.line_len   = '0;
  assign mon.line_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tb_uart.sv
// +--------------------------------------------------------------------+
// | tb_tb_uart : randomized self-checking bench for tb_uart             |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_tb_uart;

  localparam int CPB      = 16;
  localparam int LINE_LEN = 16;
  localparam int LEN_W    = $clog2(LINE_LEN + 1);

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  logic ser_rx = 1'b1;

  tb_uart_if #(.LINE_LEN(LINE_LEN)) mon ();

  tb_uart #(
    .CLKS_PER_BIT (CPB),
    .LINE_LEN     (LINE_LEN)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .ser_rx (ser_rx),
    .mon    (mon)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc++;

  // Observed events, captured mid-cycle.
  logic [7:0]            got_q[$];
  int                    got_cyc[$];
  int                    fe_cnt   = 0;
  int                    both_cnt = 0;
  int                    gl_len_q[$];
  logic [8*LINE_LEN-1:0] gl_data_q[$];

  always @(negedge clock) begin
    if (mon.rx_valid) begin
      got_q.push_back(mon.rx_data);
      got_cyc.push_back(cyc);
    end
    if (mon.frame_err) fe_cnt++;
    if (mon.rx_valid && mon.frame_err) both_cnt++;
    if (mon.line_valid) begin
      gl_len_q.push_back(int'(mon.line_len));
      gl_data_q.push_back(mon.line_data);
    end
  end

  // Reference line model: plain array of characters plus a fill count.
  logic [7:0]            mdl_buf[LINE_LEN];
  int                    mdl_cnt = 0;
  int                    el_len_q[$];
  logic [8*LINE_LEN-1:0] el_data_q[$];

  function automatic logic [8*LINE_LEN-1:0] mdl_image();
    logic [8*LINE_LEN-1:0] r;
    for (int i = 0; i < LINE_LEN; i++) r[i*8 +: 8] = mdl_buf[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINE_LEN; i++) mdl_buf[i] = 8'h00;
    mdl_cnt = 0;
  endtask

  task automatic model_feed(input logic [7:0] b);
    if (b == 8'h0D) return;
    if (b == 8'h0A) begin
      el_len_q.push_back(mdl_cnt);
      el_data_q.push_back(mdl_image());
      mdl_cnt = 0;
      return;
    end
    mdl_buf[mdl_cnt] = b;
    mdl_cnt++;
    if (mdl_cnt == LINE_LEN) begin
      el_len_q.push_back(mdl_cnt);
      el_data_q.push_back(mdl_image());
      mdl_cnt = 0;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    fe_cnt = 0;
    gl_len_q.delete();
    gl_data_q.delete();
    el_len_q.delete();
    el_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_feed(b);
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    if (mon.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %0h want 0", mon.rx_data); end
    total++;
    if ({mon.rx_valid, mon.frame_err, mon.busy, mon.line_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {mon.rx_valid, mon.frame_err, mon.busy, mon.line_valid});
    end
    total++;
    if (mon.line_len !== '0 || mon.line_data !== '0) begin
      bad++; $display("FAIL reset_line: got len %0d data %0h want 0", mon.line_len, mon.line_data);
    end
    total++;
    resetb = 1'b1;
    idle(10);
    if (mon.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", mon.busy); end
    total++;
  endtask

  task automatic test_single();
    int start;
    logic [7:0] b;
    clear_mon();
    start = cyc;
    send_good(8'hAB);
    idle(2 * CPB);
    if (got_q.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    else begin
      if (got_q[0] !== 8'hAB) begin bad++; $display("FAIL single_data: got %0h want ab", got_q[0]); end
      total++;
      if (got_cyc[0] - start < 152 || got_cyc[0] - start > 156) begin
        bad++; $display("FAIL single_latency: got %0d want 152..156", got_cyc[0] - start);
      end
      total++;
    end
    total++;
    if (fe_cnt !== 0) begin bad++; $display("FAIL single_fe: got %0d want 0", fe_cnt); end
    total++;
    if (mon.busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", mon.busy); end
    total++;
    for (int k = 0; k < 3; k++) begin
      clear_mon();
      b = 8'($urandom_range(0, 255));
      send_good(b);
      idle(CPB + $urandom_range(0, 20));
      if (got_q.size() !== 1 || got_q[0] !== b) begin
        bad++; $display("FAIL rand_single: got n=%0d d=%0h want n=1 d=%0h", got_q.size(), got_q.size() ? got_q[0] : 8'h00, b);
      end
      total++;
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    ser_rx = 1'b0;
    repeat (4) @(negedge clock);
    ser_rx = 1'b1;
    if (mon.busy !== 1'b1) begin bad++; $display("FAIL glitch_seen: got busy %b want 1", mon.busy); end
    total++;
    repeat (8) @(negedge clock);
    if (mon.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", mon.busy); end
    total++;
    idle(12 * CPB);
    if (got_q.size() !== 0 || fe_cnt !== 0) begin
      bad++; $display("FAIL glitch_output: got rx=%0d fe=%0d want 0 0", got_q.size(), fe_cnt);
    end
    total++;
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    repeat (100) @(negedge clock);
    if (fe_cnt !== 1) begin bad++; $display("FAIL fe_count: got %0d want 1", fe_cnt); end
    total++;
    if (got_q.size() !== 0) begin bad++; $display("FAIL fe_no_rx: got %0d want 0", got_q.size()); end
    total++;
    if (mon.busy !== 1'b1) begin bad++; $display("FAIL fe_break_busy: got %b want 1", mon.busy); end
    total++;
    idle(20);
    if (mon.busy !== 1'b0) begin bad++; $display("FAIL fe_release: got %b want 0", mon.busy); end
    total++;
    send_good(8'h55);
    idle(2 * CPB);
    if (got_q.size() !== 1 || got_q[0] !== 8'h55 || fe_cnt !== 1) begin
      bad++; $display("FAIL fe_recover: got n=%0d d=%0h fe=%0d want n=1 d=55 fe=1", got_q.size(), got_q.size() ? got_q[0] : 8'h00, fe_cnt);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    clear_mon();
    exp_q = '{8'h00, 8'hFF, 8'h41};
    for (int k = 0; k < 5; k++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[k]) send_good(exp_q[k]);
    idle(2 * CPB);
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    total++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, got_q[k], exp_q[k]); end
      total++;
    end
    if (both_cnt !== 0) begin bad++; $display("FAIL rx_fe_overlap: got %0d want 0", both_cnt); end
    total++;
  endtask

  task automatic test_line();
    logic [8*LINE_LEN-1:0] d;
    int n;
`ifdef TB_UART_LINEBUF_EN
    send_good(8'h0A);
    idle(CPB);
    clear_mon();
    send_good(8'h48); send_good(8'h69); send_good(8'h0D); send_good(8'h0A);
    idle(2 * CPB);
    if (gl_len_q.size() !== 1) begin bad++; $display("FAIL hi_count: got %0d want 1", gl_len_q.size()); end
    else begin
      d = gl_data_q[0];
      if (gl_len_q[0] !== 2) begin bad++; $display("FAIL hi_len: got %0d want 2", gl_len_q[0]); end
      total++;
      if (d[7:0] !== 8'h48 || d[15:8] !== 8'h69) begin
        bad++; $display("FAIL hi_chars: got %0h %0h want 48 69", d[7:0], d[15:8]);
      end
      total++;
      if (d !== el_data_q[0]) begin bad++; $display("FAIL hi_image: got %0h want %0h", d, el_data_q[0]); end
      total++;
    end
    total++;
    clear_mon();
    for (int k = 0; k < 16; k++) send_good(8'(8'h30 + k));
    idle(2 * CPB);
    if (gl_len_q.size() !== 1 || gl_len_q[0] !== LINE_LEN || gl_data_q[0] !== el_data_q[0]) begin
      bad++; $display("FAIL full_line: got n=%0d len=%0d want n=1 len=16 data %0h", gl_len_q.size(), gl_len_q.size() ? gl_len_q[0] : -1, el_data_q[0]);
    end
    total++;
    clear_mon();
    n = $urandom_range(0, 9);
    for (int k = 0; k < n; k++) send_good(8'($urandom_range(32, 126)));
    send_good(8'h0D);
    send_good(8'h0A);
    send_good(8'h0A);
    idle(2 * CPB);
    if (gl_len_q.size() !== el_len_q.size()) begin
      bad++; $display("FAIL rand_line_count: got %0d want %0d", gl_len_q.size(), el_len_q.size());
    end
    total++;
    for (int k = 0; k < el_len_q.size() && k < gl_len_q.size(); k++) begin
      if (gl_len_q[k] !== el_len_q[k] || gl_data_q[k] !== el_data_q[k]) begin
        bad++; $display("FAIL rand_line[%0d]: got len=%0d %0h want len=%0d %0h", k, gl_len_q[k], gl_data_q[k], el_len_q[k], el_data_q[k]);
      end
      total++;
    end
`else
    clear_mon();
    send_good(8'h48); send_good(8'h69); send_good(8'h0D); send_good(8'h0A);
    idle(2 * CPB);
    n = gl_len_q.size();
    d = mon.line_data;
    if (n !== 0 || d !== '0 || mon.line_len !== '0) begin
      bad++; $display("FAIL line_tied: got n=%0d len=%0d data %0h want 0", n, mon.line_len, d);
    end
    total++;
`endif
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_mon();
    b = 8'($urandom_range(0, 255));
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = b[4];
    repeat (CPB / 2) @(negedge clock);
    resetb = 1'b0;
    #1;
    if (mon.busy !== 1'b0 || mon.rx_data !== 8'h00 || mon.line_len !== '0 || mon.line_data !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b data=%0h len=%0d want 0", mon.busy, mon.rx_data, mon.line_len);
    end
    total++;
    model_reset();
    ser_rx = 1'b1;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    idle(10 * CPB);
    if (got_q.size() !== 0 || fe_cnt !== 0 || mon.busy !== 1'b0) begin
      bad++; $display("FAIL reset_discard: got rx=%0d fe=%0d busy=%b want 0 0 0", got_q.size(), fe_cnt, mon.busy);
    end
    total++;
    send_good(8'hC3);
    idle(2 * CPB);
    if (got_q.size() !== 1 || got_q[0] !== 8'hC3) begin
      bad++; $display("FAIL after_reset: got n=%0d d=%0h want n=1 d=c3", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL rx_fe_overlap_end: got %0d want 0", both_cnt); end
    total++;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_line();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
